rom_burst_reader: RTL and testbench
===================================

// Module: rom_burst_reader
// PURPOSE
// Upstream sequencer for the 8x16 dual-address ROM. On a start command it sweeps
// a burst of consecutive ROM word pairs: port 1 reads the even-offset word, port 2
// the following word. It captures the registered ROM outputs and presents each pair
// on a valid/ready output with a 2-entry buffer, so downstream backpressure never
// loses data.
// PARAMETERS
// AW     3   ROM address width (2**AW words)
// DW     16  ROM data width
// LEN_W  4   burst length field width (length counted in pairs)
// PORTS
// clk         in   1      rising-edge clock
// rst         in   1      asynchronous, active-high reset
// start       in   1      begin burst; sampled only in IDLE
// start_addr  in   AW     address of first port-1 word
// burst_len   in   LEN_W  number of pairs to read; 0 = empty burst
// busy        out  1      high from accepted start until done
// done        out  1      one-cycle completion pulse
// rom_en1     out  1      ROM port-1 enable
// rom_en2     out  1      ROM port-2 enable
// rom_addr1   out  AW     ROM port-1 address
// rom_addr2   out  AW     ROM port-2 address
// rom_dout1   in   DW     ROM port-1 data (registered in ROM, 1-cycle latency)
// rom_dout2   in   DW     ROM port-2 data
// out_valid   out  1      pair available
// out_ready   in   1      downstream accepts pair
// out_data1   out  DW     word at addr
// out_data2   out  DW     word at addr+1
// BEHAVIOUR
// - Reset (async, any time): state IDLE; busy/done/out_valid/rom_en* = 0;
//   addresses, out_data*, buffer, in-flight flag, counters = 0. Data in flight is dropped.
// - FSM: IDLE -> RUN on start with burst_len!=0. IDLE -> FIN on start with burst_len==0.
//   RUN -> DRAIN when the last pair issues. DRAIN -> FIN when the buffer is empty
//   and nothing is in flight. FIN -> IDLE unconditionally.
// - done = 1 only in FIN. busy = 1 in RUN/DRAIN/FIN and falls on IDLE entry;
//   FIN lasts exactly one cycle.
// - start is ignored outside IDLE; start_addr/burst_len are latched on accept.
// - Issue: in RUN, when (occupancy + inflight - pop) < 2, assert rom_en1 = rom_en2 = 1
//   combinationally, with rom_addr1 = ptr and rom_addr2 = ptr + 1 mod 2**AW.
//   Then ptr += 2 mod 2**AW and the remaining count decrements.
// - When not issuing, rom_en* = 0. ROM outputs are then don't-care (Z) and never captured.
// - inflight is a flag registered from the issue. At the next edge, rom_dout1/2 are
//   written to the buffer tail only if inflight = 1.
// - Latency: start sampled at edge E0 -> first issue cycle after E0 -> out_valid high
//   after E2.
// - Throughput: with out_ready held 1, one pair per cycle.
// - Buffer: 2-entry FIFO; out_valid = occupancy != 0; out_data = head entry.
//   A pop happens when out_valid & out_ready.
// - Simultaneous push and pop keeps occupancy unchanged. The credit rule above makes
//   overflow impossible.
// - While out_valid = 1 and out_ready = 0, out_data* stay stable.
// - Wrap-around: addresses wrap modulo 2**AW, including rom_addr2 when ptr = 2**AW - 1.
// TESTING (ROM image 0..7: abcd 23cd 98cd cd21 9bc7 7a3d 7430 a525)
// 1. start_addr=0, len=4, out_ready=1 -> pairs (abcd,23cd)(98cd,cd21)(9bc7,7a3d)
//    (7430,a525) on 4 consecutive cycles from E2; done one cycle after last pop.
// 2. start_addr=6, len=2 -> (7430,a525) then (abcd,23cd). start_addr=7, len=1 ->
//    (a525,abcd), with rom_addr2 = 0.
// 3. start_addr=0, len=4; drop out_ready for 3 cycles after first valid -> out_data
//    held; at most 2 pairs buffered; rom_en* low while stalled; all 4 pairs arrive in order.
// 4. len=0 -> done pulses 1 cycle after start; rom_en* never asserted; out_valid stays 0.
// 5. Pulse start with start_addr=2 mid-burst -> ignored; the original burst completes
//    unchanged.
// 6. Assert rst after the 2nd pair issues -> all outputs 0 immediately;
//    no stale pair after release; a new burst then runs correctly.

Source files
------------

// File: rtl/rom_burst_reader.sv
// Burst sequencer for a dual-port ROM: issues consecutive word pairs and
// buffers the registered ROM outputs in a 2-entry FIFO behind a valid/ready port.
module rom_burst_reader #(
  parameter int AW    = 3,
  parameter int DW    = 16,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    start_addr,
  input  logic [LEN_W-1:0] burst_len,
  output logic             busy,
  output logic             done,
  output logic             rom_en1,
  output logic             rom_en2,
  output logic [AW-1:0]    rom_addr1,
  output logic [AW-1:0]    rom_addr2,
  input  logic [DW-1:0]    rom_dout1,
  input  logic [DW-1:0]    rom_dout2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data1,
  output logic [DW-1:0]    out_data2
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic             inflight_q, inflight_d;
  logic [DW-1:0]    buf1_q [2];
  logic [DW-1:0]    buf2_q [2];
  logic [DW-1:0]    buf1_d [2];
  logic [DW-1:0]    buf2_d [2];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;
  logic             pop;
  logic             issue;
  logic [2:0]       credit;

  always_comb begin
    pop    = (occ_q != 2'd0) && out_ready;
    // Slots already committed (buffered + in flight) after this cycle's pop.
    credit = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue  = (state_q == RUN) && (credit < 3'd2);

    state_d    = state_q;
    ptr_d      = ptr_q;
    remain_d   = remain_q;
    inflight_d = issue;
    buf1_d     = buf1_q;
    buf2_d     = buf2_q;
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};

    if (inflight_q) begin
      if (tail_q) begin
        buf1_d[1] = rom_dout1;
        buf2_d[1] = rom_dout2;
      end else begin
        buf1_d[0] = rom_dout1;
        buf2_d[0] = rom_dout2;
      end
      tail_d = ~tail_q;
    end
    if (pop) head_d = ~head_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d    = start_addr;
          remain_d = burst_len;
          state_d  = (burst_len != '0) ? RUN : FIN;
        end
      end
      RUN: begin
        if (issue) begin
          ptr_d    = ptr_q + AW'(2);
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Nothing is issued here, so an empty next buffer implies nothing in flight.
        if (occ_d == 2'd0) state_d = FIN;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
      buf1_q[0]  <= '0;
      buf1_q[1]  <= '0;
      buf2_q[0]  <= '0;
      buf2_q[1]  <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      remain_q   <= remain_d;
      inflight_q <= inflight_d;
      buf1_q     <= buf1_d;
      buf2_q     <= buf2_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign rom_en1   = issue;
  assign rom_en2   = issue;
  assign rom_addr1 = issue ? ptr_q : '0;
  assign rom_addr2 = issue ? (ptr_q + AW'(1)) : '0;
  assign out_valid = (occ_q != 2'd0);
  assign out_data1 = head_q ? buf1_q[1] : buf1_q[0];
  assign out_data2 = head_q ? buf2_q[1] : buf2_q[0];

endmodule

// File: tb/tb_rom_burst_reader.sv
// Self-checking bench for rom_burst_reader: ROM model with 1-cycle latency,
// scoreboard of expected pairs/addresses derived from the burst arithmetic.
module tb_rom_burst_reader;
  localparam int AW    = 3;
  localparam int DW    = 16;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [AW-1:0]    start_addr;
  logic [LEN_W-1:0] burst_len;
  logic             busy, done;
  logic             rom_en1, rom_en2;
  logic [AW-1:0]    rom_addr1, rom_addr2;
  logic [DW-1:0]    rom_dout1, rom_dout2;
  logic             out_valid, out_ready;
  logic [DW-1:0]    out_data1, out_data2;

  logic [DW-1:0] rom [8] = '{16'habcd, 16'h23cd, 16'h98cd, 16'hcd21,
                             16'h9bc7, 16'h7a3d, 16'h7430, 16'ha525};

  int errors = 0;
  int checks = 0;

  rom_burst_reader #(.AW(AW), .DW(DW), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .burst_len(burst_len), .busy(busy), .done(done),
    .rom_en1(rom_en1), .rom_en2(rom_en2), .rom_addr1(rom_addr1),
    .rom_addr2(rom_addr2), .rom_dout1(rom_dout1), .rom_dout2(rom_dout2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data1(out_data1), .out_data2(out_data2)
  );

  always #5 clk = ~clk;

  // Disabled ports return garbage so any capture of an unissued read shows up.
  always @(posedge clk) begin
    rom_dout1 <= rom_en1 ? rom[rom_addr1] : DW'($urandom);
    rom_dout2 <= rom_en2 ? rom[rom_addr2] : DW'($urandom);
  end

  // mode 0: ready always 1; mode 1: random ready; mode 2: ready low for cycles 3..5.
  // inj_at: cycle at which a spurious start (addr 2, len 5) is pulsed, 0 = none.
  task automatic run_burst(input int a, input int len, input int mode, input int inj_at,
                           output int first_valid, output int last_pop, output int done_cyc);
    logic [DW-1:0] exp1[$];
    logic [DW-1:0] exp2[$];
    int expa[$];
    int issued = 0, popped = 0, post = 0;
    logic prev_valid = 1'b0, prev_ready = 1'b0;
    logic [DW-1:0] prev_d1 = '0, prev_d2 = '0;
    bit done_seen = 0;
    first_valid = -1; last_pop = -1; done_cyc = -1;
    for (int i = 0; i < len; i++) begin
      int ad = (a + 2 * i) % 8;
      expa.push_back(ad);
      exp1.push_back(rom[ad]);
      exp2.push_back(rom[(ad + 1) % 8]);
    end
    @(negedge clk);
    start = 1'b1; start_addr = AW'(a); burst_len = LEN_W'(len);
    out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL idle_before_start: busy=%b out_valid=%b expected 0 0", busy, out_valid);
    end
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start = (c == inj_at);
      if (c == inj_at) begin start_addr = AW'(2); burst_len = LEN_W'(5); end
      case (mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: out_ready = !(c >= 3 && c <= 5);
        default: out_ready = 1'b1;
      endcase
      #1;
      if (done_seen) begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || rom_en1 !== 1'b0) begin
          errors++;
          $display("FAIL after_done: busy=%b done=%b valid=%b en=%b expected all 0", busy, done, out_valid, rom_en1);
        end
        post = 1;
        break;
      end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_during_burst: cycle %0d got %b expected 1", c, busy); end
      checks++;
      if (rom_en1 !== rom_en2) begin errors++; $display("FAIL en_pair: en1=%b en2=%b expected equal", rom_en1, rom_en2); end
      if (rom_en1 === 1'b1) begin
        checks++;
        if (expa.size() == 0) begin
          errors++; $display("FAIL extra_issue: cycle %0d addr %0d issued, expected no issue", c, rom_addr1);
        end else begin
          int ea = expa.pop_front();
          if (rom_addr1 !== AW'(ea) || rom_addr2 !== AW'((ea + 1) % 8)) begin
            errors++;
            $display("FAIL issue_addr: got %0d/%0d expected %0d/%0d", rom_addr1, rom_addr2, ea, (ea + 1) % 8);
          end
        end
        issued++;
      end
      if (mode == 2 && c >= 3 && c <= 5) begin
        checks++;
        if (rom_en1 !== 1'b0) begin errors++; $display("FAIL issue_while_stalled: cycle %0d en=%b expected 0", c, rom_en1); end
      end
      if (prev_valid && !prev_ready) begin
        checks++;
        if (out_valid !== 1'b1 || out_data1 !== prev_d1 || out_data2 !== prev_d2) begin
          errors++;
          $display("FAIL stall_hold: got v=%b %h,%h expected v=1 %h,%h", out_valid, out_data1, out_data2, prev_d1, prev_d2);
        end
      end
      if (out_valid === 1'b1 && first_valid < 0) first_valid = c;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp1.size() == 0) begin
          errors++; $display("FAIL stale_pair: got %h,%h expected no pair", out_data1, out_data2);
        end else begin
          logic [DW-1:0] e1, e2;
          e1 = exp1.pop_front(); e2 = exp2.pop_front();
          if (out_data1 !== e1 || out_data2 !== e2) begin
            errors++; $display("FAIL pair_data: got %h,%h expected %h,%h", out_data1, out_data2, e1, e2);
          end
        end
        popped++;
        last_pop = c;
      end
      checks++;
      if (issued - popped > 2) begin
        errors++; $display("FAIL credit: outstanding %0d expected at most 2", issued - popped);
      end
      if (done === 1'b1) begin
        done_seen = 1;
        done_cyc = c;
        checks++;
        if (popped != len || expa.size() != 0 || c != ((len == 0) ? 1 : last_pop + 1)) begin
          errors++;
          $display("FAIL done_timing: cycle %0d pops %0d expected cycle %0d pops %0d", c, popped,
                   (len == 0) ? 1 : last_pop + 1, len);
        end
      end
      prev_valid = out_valid; prev_ready = out_ready;
      prev_d1 = out_data1; prev_d2 = out_data2;
    end
    start = 1'b0;
    if (post == 0) begin
      checks++; errors++;
      $display("FAIL burst_timeout: done_seen=%0d expected done within 300 cycles", done_seen);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_addr = '0; burst_len = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({busy, done, out_valid, rom_en1, rom_en2, rom_addr1, rom_addr2, out_data1, out_data2} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b v=%b en=%b%b a=%0d/%0d d=%h,%h expected all 0",
               busy, done, out_valid, rom_en1, rom_en2, rom_addr1, rom_addr2, out_data1, out_data2);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_burst();
    int fv, lp, dc;
    run_burst(0, 4, 0, 0, fv, lp, dc);
    checks++;
    if (fv != 3 || lp != 6 || dc != 7) begin
      errors++; $display("FAIL burst_latency: first=%0d last=%0d done=%0d expected 3 6 7", fv, lp, dc);
    end
  endtask

  task automatic test_wrap();
    int fv, lp, dc;
    run_burst(6, 2, 0, 0, fv, lp, dc);
    run_burst(7, 1, 0, 0, fv, lp, dc);
    checks++;
    if (fv != 3 || dc != 4) begin
      errors++; $display("FAIL wrap_latency: first=%0d done=%0d expected 3 4", fv, dc);
    end
  endtask

  task automatic test_backpressure();
    int fv, lp, dc;
    run_burst(0, 4, 2, 0, fv, lp, dc);
    checks++;
    if (fv != 3) begin errors++; $display("FAIL stall_first_valid: got %0d expected 3", fv); end
  endtask

  task automatic test_empty();
    int fv, lp, dc;
    run_burst(int'($urandom_range(0, 7)), 0, 0, 0, fv, lp, dc);
    checks++;
    if (dc != 1 || fv != -1) begin
      errors++; $display("FAIL empty_burst: done=%0d first_valid=%0d expected 1 -1", dc, fv);
    end
  endtask

  task automatic test_start_ignored();
    int fv, lp, dc;
    run_burst(0, 4, 0, 2, fv, lp, dc);
  endtask

  task automatic test_reset_mid();
    int fv, lp, dc, n_iss = 0;
    @(negedge clk);
    start = 1'b1; start_addr = '0; burst_len = LEN_W'(4); out_ready = 1'b1;
    for (int c = 1; c <= 10 && n_iss < 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (rom_en1 === 1'b1) n_iss++;
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, out_valid, rom_en1, rom_en2, rom_addr1, rom_addr2, out_data1, out_data2} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: busy=%b done=%b v=%b en=%b%b a=%0d/%0d d=%h,%h expected all 0",
               busy, done, out_valid, rom_en1, rom_en2, rom_addr1, rom_addr2, out_data1, out_data2);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || rom_en1 !== 1'b0) begin
        errors++; $display("FAIL post_reset_idle: v=%b busy=%b en=%b expected 0 0 0", out_valid, busy, rom_en1);
      end
    end
    run_burst(3, 3, 1, 0, fv, lp, dc);
  endtask

  task automatic test_random();
    int fv, lp, dc;
    for (int k = 0; k < 8; k++)
      run_burst(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 1, int'($urandom_range(0, 6)), fv, lp, dc);
    run_burst(5, 15, 0, 0, fv, lp, dc);
    checks++;
    if (lp - fv != 14) begin
      errors++; $display("FAIL throughput: pops spanned %0d cycles expected 15", lp - fv + 1);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_wrap();
    test_backpressure();
    test_empty();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
